// File: rtl/ntlm_candidate_gen.sv
// Brute-force candidate enumerator feeding Calculate_NTLM: every string over the charset,
// shortest first. Define NTLM_CHARSET_DIGITS_EN to append '0'..'9' to the lowercase charset.
module ntlm_candidate_gen #(
  parameter int MIN_LEN = 1,
  parameter int MAX_LEN = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic         cand_ready,
  output logic         cand_valid,
  output logic [0:127] instr,
  output logic [0:3]   length,
  output logic         done,
  output logic [0:31]  cand_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

`ifdef NTLM_CHARSET_DIGITS_EN
  localparam int CHARSET_N = 36;
`else
  localparam int CHARSET_N = 26;
`endif
  localparam logic [5:0] IDX_LAST = 6'(CHARSET_N - 1);

  function automatic logic [7:0] char_of(input logic [5:0] i);
`ifdef NTLM_CHARSET_DIGITS_EN
    if (i < 6'd26) return 8'h61 + {2'b00, i};
    else           return 8'h30 + {2'b00, i - 6'd26};
`else
    return 8'h61 + {2'b00, i};
`endif
  endfunction

  state_e       state_q, state_d;
  logic [5:0]   idx_q [MAX_LEN];
  logic [5:0]   idx_d [MAX_LEN];
  logic [5:0]   idx_adv [MAX_LEN];
  logic [3:0]   len_q, len_d;
  logic [31:0]  count_q, count_d;
  logic [0:127] instr_q, instr_d;
  logic         wrap_all;

  // Odometer increment: position len-1 is least significant; wrap_all is the carry out of idx[0].
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    idx_adv  = idx_q;
    wrap_all = 1'b1;
    for (int k = MAX_LEN - 1; k >= 0; k--) begin
      if (k < int'(len_q) && wrap_all) begin
        if (idx_q[k] == IDX_LAST) begin
          idx_adv[k] = '0;
        end else begin
          idx_adv[k] = idx_q[k] + 6'd1;
          wrap_all   = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    count_d = count_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          len_d   = 4'(MIN_LEN);
          idx_d   = '{default: '0};
          count_d = '0;
        end
      end
      ST_RUN: begin
        if (cand_ready && count_q != '1) count_d = count_q + 32'd1;
        // A hash match freezes the current candidate even if it was just accepted.
        if (stop) begin
          state_d = ST_DONE;
        end else if (cand_ready) begin
          if (!wrap_all) begin
            idx_d = idx_adv;
          end else if (int'(len_q) < MAX_LEN) begin
            len_d = len_q + 4'd1;
            idx_d = '{default: '0};
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    instr_d = '0;
    for (int k = 0; k < MAX_LEN; k++) begin
      if (k < int'(len_d)) instr_d[8*k +: 8] = char_of(idx_d[k]);
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only, so every flop
  // samples the pre-edge values; the index array is tiny and is reset along with everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '{default: '0};
      len_q   <= '0;
      count_q <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      count_q <= count_d;
      instr_q <= instr_d;
    end
  end

  assign cand_valid = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign instr      = instr_q;
  assign length     = len_q;
  assign cand_count = count_q;

endmodule

// File: tb/tb_ntlm_candidate_gen.sv
// Directed bench: ordering, backpressure, stop, reset and restart on two parameterisations.
module tb_ntlm_candidate_gen;

`ifdef NTLM_CHARSET_DIGITS_EN
  localparam int N = 36;
  localparam logic [127:0] C27   = {8'h30, 120'h0};
  localparam logic [127:0] C28   = {8'h31, 120'h0};
  localparam logic [3:0]   LEN27 = 4'd1;
  localparam logic [127:0] CLAST = {16'h3939, 112'h0};
`else
  localparam int N = 26;
  localparam logic [127:0] C27   = {16'h6161, 112'h0};
  localparam logic [127:0] C28   = {16'h6162, 112'h0};
  localparam logic [3:0]   LEN27 = 4'd2;
  localparam logic [127:0] CLAST = {16'h7A7A, 112'h0};
`endif
  localparam logic [127:0] C_A    = {8'h61, 120'h0};
  localparam logic [127:0] C_B    = {8'h62, 120'h0};
  localparam logic [127:0] C_K    = {8'h6B, 120'h0};
  localparam logic [127:0] C_Z    = {8'h7A, 120'h0};
  localparam logic [127:0] C_AAAABC = {48'h616161616263, 80'h0};

  logic clk = 1'b0;
  logic rst;
  logic a_start, a_stop, a_ready, a_valid, a_done;
  logic [0:127] a_instr;
  logic [0:3]   a_length;
  logic [0:31]  a_count;
  logic b_start, b_stop, b_ready, b_valid, b_done;
  logic [0:127] b_instr;
  logic [0:3]   b_length;
  logic [0:31]  b_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ntlm_candidate_gen #(.MIN_LEN(1), .MAX_LEN(2)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .stop(a_stop), .cand_ready(a_ready),
    .cand_valid(a_valid), .instr(a_instr), .length(a_length), .done(a_done),
    .cand_count(a_count)
  );

  ntlm_candidate_gen #(.MIN_LEN(6), .MAX_LEN(6)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .stop(b_stop), .cand_ready(b_ready),
    .cand_valid(b_valid), .instr(b_instr), .length(b_length), .done(b_done),
    .cand_count(b_count)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    a_start = 0; a_stop = 0; a_ready = 0;
    b_start = 0; b_stop = 0; b_ready = 0;
    step(2);
    rst = 1'b0;
    check("rst_valid", a_valid, 0);
    check("rst_done", a_done, 0);
    check("rst_instr", a_instr, 0);
    check("rst_length", a_length, 0);
    check("rst_count", a_count, 0);

    // Start with backpressure: first candidate appears one cycle after start.
    a_start = 1;
    step();
    a_start = 0;
    check("first_valid", a_valid, 1);
    check("first_instr", a_instr, C_A);
    check("first_length", a_length, 1);
    check("first_count", a_count, 0);

    step(5);
    check("bp_instr", a_instr, C_A);
    check("bp_length", a_length, 1);
    check("bp_count", a_count, 0);

    a_ready = 1;
    step();
    check("adv_instr", a_instr, C_B);
    check("adv_count", a_count, 1);
    step(24);
    check("c26_instr", a_instr, C_Z);
    check("c26_count", a_count, 25);
    step();
    check("c27_instr", a_instr, C27);
    check("c27_length", a_length, LEN27);

    // start while running must not disturb the sequence.
    a_start = 1;
    step();
    a_start = 0;
    check("start_in_run_instr", a_instr, C28);
    check("start_in_run_count", a_count, 27);
    check("start_in_run_done", a_done, 0);

    for (int i = 0; i < 2000 && !a_done; i++) step();
    check("end_done", a_done, 1);
    check("end_count", a_count, N + N * N);
    check("end_valid", a_valid, 0);
    check("end_instr", a_instr, CLAST);
    check("end_length", a_length, 2);

    // Restart from DONE.
    a_start = 1;
    step();
    a_start = 0;
    check("restart_done", a_done, 0);
    check("restart_valid", a_valid, 1);
    check("restart_instr", a_instr, C_A);
    check("restart_count", a_count, 0);

    // Reset mid-run after 10 accepts.
    step(10);
    check("mid_count", a_count, 10);
    check("mid_instr", a_instr, C_K);
    rst = 1;
    step();
    rst = 0;
    check("midrst_valid", a_valid, 0);
    check("midrst_done", a_done, 0);
    check("midrst_count", a_count, 0);
    check("midrst_instr", a_instr, 0);
    a_start = 1;
    a_ready = 0;
    step();
    a_start = 0;
    check("after_rst_instr", a_instr, C_A);

    // Stop without accept: frozen, count unchanged.
    a_stop = 1;
    step();
    a_stop = 0;
    check("stop_noacc_done", a_done, 1);
    check("stop_noacc_valid", a_valid, 0);
    check("stop_noacc_count", a_count, 0);
    check("stop_noacc_instr", a_instr, C_A);

    // Six-character run: stop on "aaaabc" with a simultaneous accept.
    b_ready = 1;
    b_start = 1;
    step();
    b_start = 0;
    check("b_first_length", b_length, 6);
    check("b_first_instr", b_instr, {48'h616161616161, 80'h0});
    step(N + 2);
    check("b_target_instr", b_instr, C_AAAABC);
    b_stop = 1;
    step();
    b_stop = 0;
    check("b_stop_done", b_done, 1);
    check("b_stop_valid", b_valid, 0);
    check("b_stop_instr", b_instr, C_AAAABC);
    check("b_stop_count", b_count, N + 3);
    step(3);
    check("b_hold_instr", b_instr, C_AAAABC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ntlm_candidate_gen.md
Name: ntlm_candidate_gen

Overview:
- Brute-force password candidate enumerator; sits directly upstream of Calculate_NTLM.
- Drives its instr and length inputs with every string over a fixed charset, shortest length first.
- Downstream consumes candidates over a valid/ready handshake.
- A stop input, asserted on hash match, freezes enumeration so the matching candidate can be read back.

Parameters:
- MIN_LEN, 1, first candidate length in characters (1..MAX_LEN)
- MAX_LEN, 6, last candidate length in characters (MIN_LEN..15; limited by the 4-bit length port)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  begin enumeration; sampled in IDLE or DONE
- stop  input  1  halt request (hash match found)
- cand_ready  input  1  downstream accepts candidate
- cand_valid  output  1  instr/length hold a valid candidate
- instr  output  [0:127]  candidate string; char k at bits [8k:8k+7], ASCII; bytes at k >= length are 0x00
- length  output  [0:3]  candidate length in characters
- done  output  1  enumeration finished or stopped
- cand_count  output  [0:31]  number of accepted candidates, saturating at 0xFFFFFFFF

Behaviour:
- Reset (synchronous, active-high): state IDLE; cand_valid=0, done=0, instr=0, length=0, cand_count=0. rst overrides every other input, including mid-RUN.
- Internal state: MAX_LEN index registers idx[k], 6 bits each, plus a current-length register len.
  - instr byte k = charset[idx[k]] for k < len, else 0x00.
  - Base charset (N=26): idx 0..25 maps to 'a'..'z' (0x61..0x7A).
- IDLE:
  - cand_valid=0, done=0.
  - start=1 -> RUN next edge; len=MIN_LEN, all idx=0, cand_count=0.
- RUN:
  - cand_valid=1; instr/length held stable while cand_valid && !cand_ready.
  - Accept means cand_valid && cand_ready at an edge: cand_count+1 and the candidate advances on that same edge.
  - Advance is an odometer. Position len-1 is least significant: increment idx[len-1]; on reaching N, wrap to 0 and carry into idx[len-2], and so on toward idx[0].
  - Carry out of idx[0] (all positions were N-1) with len < MAX_LEN: len+1, all idx=0.
  - Carry out of idx[0] with len == MAX_LEN: last candidate accepted -> DONE; cand_valid=0 next cycle.
  - One candidate per cycle max; ready tied high gives full-rate output, zero-bubble.
  - start in RUN is ignored.
- stop in RUN:
  - -> DONE next edge; instr/length frozen at the current candidate (not advanced).
  - If an accept occurs on the same edge, cand_count still increments but the candidate does not advance.
  - stop has priority over advance and over last-candidate termination.
- DONE:
  - done=1, cand_valid=0; instr/length/cand_count held.
  - start=1 -> restart exactly as from IDLE (done drops next edge). stop has no effect.
- Output latency: outputs are registered; first candidate is valid 1 cycle after start is sampled.
- cand_count saturates; no wrap.

Optional Feature:
- Macro: NTLM_CHARSET_DIGITS_EN.
- Defined: N=36; idx 26..35 map to '0'..'9' (0x30..0x39), ordered after 'z'.
- Undefined: N=26, lowercase only; index values >= 26 are never produced.

Test Plan:
- Order, MIN_LEN=1, MAX_LEN=2, ready=1, pulse start:
  - 1st candidate instr[0:7]=0x61, length=1, bits [8:127]=0.
  - 26th candidate = 0x7A.
  - 27th candidate = "aa" (0x6161), length=2.
  - done after 702 accepts; cand_count=702.
  - With NTLM_CHARSET_DIGITS_EN: 1332 candidates; 27th='0'; 37th="aa".
- Backpressure: ready=0 for 5 cycles while valid -> instr/length/cand_count unchanged. ready=1 -> advances 1 per cycle.
- Stop, MIN_LEN=MAX_LEN=6: assert stop when instr="aaaabc" (0x616161616263) -> done=1 next cycle, cand_valid=0, instr held at "aaaabc".
- Stop with simultaneous accept -> cand_count +1, instr not advanced.
- Reset mid-RUN, after 10 accepts: rst=1 -> next edge cand_valid=0, done=0, cand_count=0, instr=0. start -> restarts at "a".
- Restart from DONE: start pulse -> first candidate again "a", cand_count=0. start pulse during RUN -> no effect on sequence.
